romulus_tbc_sequencer: RTL and testbench

Control stage directly upstream of the Romulus datapath: on command it runs one full SKINNY-128-384+ TBC call or one standalone counter update. It drives the datapath's round-constant bus and its state/tweakey enable strobes (`sen/senc`, `xen/xenc`, `yen/yenc`, `zen/zenc`, `correct_cnt`). The Romulus mode controller talks to it through a start/ready/done handshake and does not sequence rounds itself.

---
 rtl/romulus_tbc_sequencer.sv | 127 ++++++++++++
 tb/tb_romulus_tbc_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/romulus_tbc_sequencer.sv
// Round/tweakey sequencer for the Romulus SKINNY-128-384+ datapath.
// Runs one full TBC call or one counter-only update per command.
module romulus_tbc_sequencer #(
   parameter int ROUNDS = 40,
   parameter int UNROLL = 2,
   parameter int CONSTW = 6*UNROLL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_tbc,
   input  logic              start_cnt,
   output logic              ready,
   output logic              done,
   output logic [CONSTW-1:0] constant,
   output logic              sen,
   output logic              senc,
   output logic              xen,
   output logic              xenc,
   output logic              yen,
   output logic              yenc,
   output logic              zen,
   output logic              zenc,
   output logic              correct_cnt
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ROUND   = 2'd1;
   localparam logic [1:0] S_CORRECT = 2'd2;
   localparam logic [1:0] S_CNT     = 2'd3;

   localparam int         CYCLES = ROUNDS/UNROLL;
   localparam logic [5:0] LAST   = 6'(CYCLES-1);

   logic [1:0] state;
   logic [5:0] rnd;
   logic [5:0] lfsr;
   logic [5:0] lfsr_adv;
   logic [5:0] rc;

   // Unroll the LFSR: each step yields one round's constant.
   always_comb begin
      rc       = lfsr;
      constant = '0;
      for (int k = 0; k < UNROLL; k++) begin
         rc = {rc[4:0], ~(rc[5] ^ rc[4])};
         constant[CONSTW-1-6*k -: 6] = rc;
      end
      lfsr_adv = rc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         rnd   <= '0;
         lfsr  <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_tbc) begin
                  state <= S_ROUND;
                  rnd   <= '0;
               end else if (start_cnt) begin
                  state <= S_CNT;
               end
            end
            S_ROUND: begin
               rnd <= rnd + 6'd1;
               // Reload early so CORRECT/IDLE already show the first-cycle constants.
               if (rnd == LAST) begin
                  state <= S_CORRECT;
                  lfsr  <= '0;
               end else begin
                  lfsr <= lfsr_adv;
               end
            end
            S_CORRECT: begin
               state <= S_IDLE;
               done  <= 1'b1;
            end
            S_CNT: begin
               state <= S_IDLE;
               done  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      ready       = 1'b0;
      sen         = 1'b0;
      senc        = 1'b0;
      xen         = 1'b0;
      xenc        = 1'b0;
      yen         = 1'b0;
      yenc        = 1'b0;
      zen         = 1'b0;
      zenc        = 1'b0;
      correct_cnt = 1'b0;
      case (state)
         S_IDLE: ready = 1'b1;
         S_ROUND: begin
            sen  = 1'b1;
            senc = 1'b1;
            xen  = 1'b1;
            xenc = 1'b1;
            yen  = 1'b1;
            yenc = 1'b1;
            zen  = 1'b1;
            zenc = 1'b1;
         end
         S_CORRECT: begin
            xen = 1'b1;
            yen = 1'b1;
            zen = 1'b1;
         end
         S_CNT: begin
            zen         = 1'b1;
            correct_cnt = 1'b1;
         end
         default: ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_romulus_tbc_sequencer.sv
// Scoreboard bench for romulus_tbc_sequencer, UNROLL=2 and UNROLL=1 instances
// sharing one stimulus stream, checked against a command-level model.
module tb_romulus_tbc_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_tbc = 1'b0;
   logic start_cnt = 1'b0;

   logic        rdy0, dn0, sen0, senc0, xen0, xenc0, yen0, yenc0;
   logic        zen0, zenc0, cc0;
   logic [11:0] c0;
   logic        rdy1, dn1, sen1, senc1, xen1, xenc1, yen1, yenc1;
   logic        zen1, zenc1, cc1;
   logic [5:0]  c1;

   always #5 clk = ~clk;

   romulus_tbc_sequencer #(.ROUNDS(40), .UNROLL(2)) u0 (
      .clk(clk), .rst(rst), .start_tbc(start_tbc), .start_cnt(start_cnt),
      .ready(rdy0), .done(dn0), .constant(c0),
      .sen(sen0), .senc(senc0), .xen(xen0), .xenc(xenc0),
      .yen(yen0), .yenc(yenc0), .zen(zen0), .zenc(zenc0),
      .correct_cnt(cc0)
   );

   romulus_tbc_sequencer #(.ROUNDS(40), .UNROLL(1)) u1 (
      .clk(clk), .rst(rst), .start_tbc(start_tbc), .start_cnt(start_cnt),
      .ready(rdy1), .done(dn1), .constant(c1),
      .sen(sen1), .senc(senc1), .xen(xen1), .xenc(xenc1),
      .yen(yen1), .yenc(yenc1), .zen(zen1), .zenc(zenc1),
      .correct_cnt(cc1)
   );

   typedef struct packed {
      logic        rdy;
      logic        dn;
      logic [8:0]  st;
      logic [11:0] cs;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int checks = 0;
   int errors = 0;

   logic [5:0] seq [40] = '{
      6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
      6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
      6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
      6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
   };

   // Model: command kind (0 idle, 1 tbc, 2 cnt), cycles since acceptance.
   int unr  [2] = '{2, 1};
   int kind [2] = '{0, 0};
   int pos  [2] = '{0, 0};
   bit dnm  [2] = '{1'b0, 1'b0};

   function automatic logic [11:0] cexp(int u, int base);
      logic [11:0] r;
      r = '0;
      for (int k = 0; k < u; k++)
         r = {r[5:0], seq[base+k]};
      return r;
   endfunction

   function automatic exp_t expect_of(int d);
      exp_t e;
      int   u;
      int   n;
      u     = unr[d];
      n     = 40 / u;
      e     = '0;
      e.dn  = dnm[d];
      e.rdy = (kind[d] == 0);
      e.cs  = cexp(u, 0);
      if (kind[d] == 1 && pos[d] <= n) begin
         e.st = 9'b111111110;
         e.cs = cexp(u, (pos[d]-1)*u);
      end else if (kind[d] == 1) begin
         e.st = 9'b001010100;
      end else if (kind[d] == 2) begin
         e.st = 9'b000000101;
      end
      return e;
   endfunction

   task automatic step(int d, logic t, logic c, logic r);
      int n;
      n = 40 / unr[d];
      if (r) begin
         kind[d] = 0;
         dnm[d]  = 1'b0;
      end else if (kind[d] == 0) begin
         dnm[d] = 1'b0;
         if (t) begin
            kind[d] = 1;
            pos[d]  = 1;
         end else if (c) begin
            kind[d] = 2;
            pos[d]  = 1;
         end
      end else begin
         pos[d] = pos[d] + 1;
         dnm[d] = 1'b0;
         if ((kind[d] == 1 && pos[d] > n+1) ||
             (kind[d] == 2 && pos[d] > 1)) begin
            kind[d] = 0;
            dnm[d]  = 1'b1;
         end
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected next cycle.
   task automatic cyc(logic t, logic c, logic r);
      start_tbc = t;
      start_cnt = c;
      rst       = r;
      step(0, t, c, r);
      step(1, t, c, r);
      q0.push_back(expect_of(0));
      q1.push_back(expect_of(1));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         chk("u0_ready", {11'd0, rdy0}, {11'd0, e.rdy});
         chk("u0_done", {11'd0, dn0}, {11'd0, e.dn});
         chk("u0_strobes",
             {3'd0, sen0, senc0, xen0, xenc0, yen0, yenc0, zen0, zenc0, cc0},
             {3'd0, e.st});
         chk("u0_constant", c0, e.cs);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         chk("u1_ready", {11'd0, rdy1}, {11'd0, e.rdy});
         chk("u1_done", {11'd0, dn1}, {11'd0, e.dn});
         chk("u1_strobes",
             {3'd0, sen1, senc1, xen1, xenc1, yen1, yenc1, zen1, zenc1, cc1},
             {3'd0, e.st});
         chk("u1_constant", {6'd0, c1}, e.cs);
      end
   end

   initial begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      idle(5);
      // Single TBC
      cyc(1'b1, 1'b0, 1'b0);
      idle(45);
      // Counter-only update
      cyc(1'b0, 1'b1, 1'b0);
      idle(4);
      // Simultaneous starts
      cyc(1'b1, 1'b1, 1'b0);
      idle(45);
      // Start while busy, then back-to-back in the done cycle
      cyc(1'b1, 1'b0, 1'b0);
      idle(4);
      cyc(1'b0, 1'b1, 1'b0);
      idle(16);
      cyc(1'b1, 1'b0, 1'b0);
      idle(45);
      // Reset mid-op
      cyc(1'b1, 1'b0, 1'b0);
      idle(6);
      cyc(1'b0, 1'b0, 1'b1);
      idle(5);
      // Full UNROLL=1 run
      cyc(1'b1, 1'b0, 1'b0);
      idle(50);
      // Held start re-issues on every ready
      for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 500; i++)
         cyc(($urandom % 6) == 0, ($urandom % 5) == 0,
             ($urandom % 150) == 0);
      idle(2);
      for (int i = 0; i < 10 && (q0.size() + q1.size()) > 0; i++)
         @(negedge clk);
      #1;
      if ((q0.size() + q1.size()) > 0) begin
         errors++;
         $display("FAIL drain left=%0d want=0", q0.size() + q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
